// File: rtl/inst_sequencer_pkg.sv
// Shared constants for the instruction sequencer: instruction field layout,
// opcode values, sequencer FSM states and small opcode classification helpers.
package inst_sequencer_pkg;

  localparam int INST_BITS   = 20;
  localparam int OPCODE_FROM = 19;
  localparam int OPCODE_TO   = 16;
  localparam int ADDRA_FROM  = 15;
  localparam int ADDRA_TO    = 8;
  localparam int ADDRB_FROM  = 7;
  localparam int ADDRB_TO    = 0;

  localparam logic [3:0] IDLE_INST         = 4'd0;
  localparam logic [3:0] WRITE_DATA_INST   = 4'd1;
  localparam logic [3:0] WRITE_WEIGHT_INST = 4'd2;
  localparam logic [3:0] LOAD_DATA_INST    = 4'd3;
  localparam logic [3:0] LOAD_WEIGHT_INST  = 4'd4;
  localparam logic [3:0] MAT_MUL_INST      = 4'd5;
  localparam logic [3:0] MAT_MUL_ACC_INST  = 4'd6;
  localparam logic [3:0] WRITE_RESULT_INST = 4'd7;
  localparam logic [3:0] READ_UB_INST      = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2
  } seq_state_e;

  // AXI-type opcodes must also wait for the array's busy flag to drop
  function automatic logic isAxiOp(input logic [3:0] op);
    return (op == WRITE_DATA_INST) || (op == WRITE_WEIGHT_INST) || (op == READ_UB_INST);
  endfunction

  function automatic logic isLegalOp(input logic [3:0] op);
    return op <= READ_UB_INST;
  endfunction

endpackage

// File: rtl/inst_sequencer_if.sv
// Host command channel into the sequencer: valid/ready handshake with a
// 20-bit instruction word.
interface inst_sequencer_if;
  import inst_sequencer_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [INST_BITS-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);

endinterface

// File: rtl/inst_sequencer_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued instructions.
// Pushes while full and pops while empty are ignored.
module inst_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign dout_o  = mem_q[rdPtr_q];

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_sequencer.sv
// Instruction sequencer: queues host instructions and holds each one on the
// systolic array's instruction port for its opcode budget (plus busy wait).
module inst_sequencer import inst_sequencer_pkg::*; #(
  parameter int DEPTH       = 16,
  parameter int CYC_IDLE    = 1,
  parameter int CYC_WDATA   = 4,
  parameter int CYC_WWEIGHT = 4,
  parameter int CYC_LDATA   = 2,
  parameter int CYC_LWEIGHT = 2,
  parameter int CYC_MMUL    = 33,
  parameter int CYC_WRES    = 2,
  parameter int CYC_RUB     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_i,
  inst_sequencer_if.slave      cmd,
  input  logic                 sa_busy_i,
  output logic [INST_BITS-1:0] instruction_o,
  output logic                 retire_o,
  output logic [15:0]          issue_count_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 err_opcode_o
);

  seq_state_e           state_q;
  logic [INST_BITS-1:0] inst_q;
  logic [INST_BITS-1:0] inst_d;
  logic [5:0]           cnt_q;
  logic [5:0]           cnt_d;
  logic                 retire_q;
  logic                 err_q;
  logic [15:0]          issueCnt_q;

  logic [INST_BITS-1:0] fifoDout;
  logic                 fifoEmpty;
  logic                 fifoFull;
  logic                 pop;
  logic                 doRetire;
  logic                 headLegal;
  logic [3:0]           headOp;
  logic [3:0]           curOp;

  // Illegal opcodes fall to the default arm and get a single-cycle budget
  function automatic logic [5:0] budgetOf(input logic [3:0] op);
    case (op)
      IDLE_INST:                     return 6'(CYC_IDLE);
      WRITE_DATA_INST:               return 6'(CYC_WDATA);
      WRITE_WEIGHT_INST:             return 6'(CYC_WWEIGHT);
      LOAD_DATA_INST:                return 6'(CYC_LDATA);
      LOAD_WEIGHT_INST:              return 6'(CYC_LWEIGHT);
      MAT_MUL_INST, MAT_MUL_ACC_INST: return 6'(CYC_MMUL);
      WRITE_RESULT_INST:             return 6'(CYC_WRES);
      READ_UB_INST:                  return 6'(CYC_RUB);
      default:                       return 6'd1;
    endcase
  endfunction

  inst_fifo #(
    .WIDTH (INST_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cmd.cmd_valid),
    .pop_i   (pop),
    .din_i   (cmd.cmd_data),
    .dout_o  (fifoDout),
    .empty_o (fifoEmpty),
    .full_o  (fifoFull)
  );

  // An illegal head is stored as 0, so curOp never reports an AXI wait for it
  always_comb begin
    headOp    = fifoDout[OPCODE_FROM:OPCODE_TO];
    curOp     = inst_q[OPCODE_FROM:OPCODE_TO];
    headLegal = isLegalOp(headOp);
    inst_d    = headLegal ? fifoDout : '0;
    cnt_d     = budgetOf(headOp) - 6'd1;
    doRetire  = ((state_q == S_EXEC) && (cnt_q == '0) && !isAxiOp(curOp)) ||
                ((state_q == S_WAIT) && !sa_busy_i);
    pop       = run_i && !fifoEmpty && ((state_q == S_IDLE) || doRetire);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      inst_q     <= '0;
      cnt_q      <= '0;
      retire_q   <= 1'b0;
      issueCnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      retire_q <= doRetire;
      if (doRetire) issueCnt_q <= issueCnt_q + 16'd1;
      if (pop) begin
        inst_q  <= inst_d;
        cnt_q   <= cnt_d;
        state_q <= S_EXEC;
        if (!headLegal) err_q <= 1'b1;
      end else if (doRetire) begin
        inst_q  <= '0;
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_EXEC: begin
            if (cnt_q != '0) cnt_q <= cnt_q - 6'd1;
            else             state_q <= S_WAIT;
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd.cmd_ready  = !fifoFull;
  assign instruction_o  = inst_q;
  assign retire_o       = retire_q;
  assign issue_count_o  = issueCnt_q;
  assign empty_o        = fifoEmpty;
  assign full_o         = fifoFull;
  assign err_opcode_o   = err_q;

endmodule
